// File: rtl/mc10_kb_pkg.sv
// MC-10 keyboard shared types: key-map entry, special-row constants and the
// PS/2 set-2 scancode to matrix-position table.
package mc10_kb_pkg;

  localparam logic [2:0] ROW_SPECIAL = 3'd6;
  localparam logic [2:0] COL_SHIFT   = 3'd7;
  localparam logic [2:0] COL_CTRL    = 3'd0;
  localparam logic [2:0] COL_BREAK   = 3'd2;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
    logic       vshift;
  } kb_entry_t;

  function automatic kb_entry_t kb_ent(input logic [2:0] row, input logic [2:0] col,
                                       input logic vshift);
    kb_entry_t e;
    e.hit    = 1'b1;
    e.row    = row;
    e.col    = col;
    e.vshift = vshift;
    return e;
  endfunction

  // Index is {extended, scancode}; unlisted codes return hit=0.
  function automatic kb_entry_t kb_map(input logic [8:0] key);
    kb_entry_t e;
    e = '0;
    case (key)
      // row 0: @ A B C D E F G
      9'h01C: e = kb_ent(3'd0, 3'd1, 1'b0);  // A
      9'h032: e = kb_ent(3'd0, 3'd2, 1'b0);  // B
      9'h021: e = kb_ent(3'd0, 3'd3, 1'b0);  // C
      9'h023: e = kb_ent(3'd0, 3'd4, 1'b0);  // D
      9'h024: e = kb_ent(3'd0, 3'd5, 1'b0);  // E
      9'h02B: e = kb_ent(3'd0, 3'd6, 1'b0);  // F
      9'h034: e = kb_ent(3'd0, 3'd7, 1'b0);  // G
      // row 1: H I J K L M N O
      9'h033: e = kb_ent(3'd1, 3'd0, 1'b0);
      9'h043: e = kb_ent(3'd1, 3'd1, 1'b0);
      9'h03B: e = kb_ent(3'd1, 3'd2, 1'b0);
      9'h042: e = kb_ent(3'd1, 3'd3, 1'b0);
      9'h04B: e = kb_ent(3'd1, 3'd4, 1'b0);
      9'h03A: e = kb_ent(3'd1, 3'd5, 1'b0);
      9'h031: e = kb_ent(3'd1, 3'd6, 1'b0);
      9'h044: e = kb_ent(3'd1, 3'd7, 1'b0);
      // row 2: P Q R S T U V W
      9'h04D: e = kb_ent(3'd2, 3'd0, 1'b0);
      9'h015: e = kb_ent(3'd2, 3'd1, 1'b0);
      9'h02D: e = kb_ent(3'd2, 3'd2, 1'b0);
      9'h01B: e = kb_ent(3'd2, 3'd3, 1'b0);
      9'h02C: e = kb_ent(3'd2, 3'd4, 1'b0);
      9'h03C: e = kb_ent(3'd2, 3'd5, 1'b0);
      9'h02A: e = kb_ent(3'd2, 3'd6, 1'b0);
      9'h01D: e = kb_ent(3'd2, 3'd7, 1'b0);
      // row 3: X Y Z . . . ENTER SPACE
      9'h022: e = kb_ent(3'd3, 3'd0, 1'b0);
      9'h035: e = kb_ent(3'd3, 3'd1, 1'b0);
      9'h01A: e = kb_ent(3'd3, 3'd2, 1'b0);
      9'h05A: e = kb_ent(3'd3, 3'd6, 1'b0);
      9'h029: e = kb_ent(3'd3, 3'd7, 1'b0);
      // row 4: 0..7
      9'h045: e = kb_ent(3'd4, 3'd0, 1'b0);
      9'h016: e = kb_ent(3'd4, 3'd1, 1'b0);
      9'h01E: e = kb_ent(3'd4, 3'd2, 1'b0);
      9'h026: e = kb_ent(3'd4, 3'd3, 1'b0);
      9'h025: e = kb_ent(3'd4, 3'd4, 1'b0);
      9'h02E: e = kb_ent(3'd4, 3'd5, 1'b0);
      9'h036: e = kb_ent(3'd4, 3'd6, 1'b0);
      9'h03D: e = kb_ent(3'd4, 3'd7, 1'b0);
      9'h052: e = kb_ent(3'd4, 3'd7, 1'b1);  // PC ' is SHIFT+7 on the MC-10
      // row 5: 8 9 : ; , - . /
      9'h03E: e = kb_ent(3'd5, 3'd0, 1'b0);
      9'h046: e = kb_ent(3'd5, 3'd1, 1'b0);
      9'h04C: e = kb_ent(3'd5, 3'd3, 1'b0);
      9'h041: e = kb_ent(3'd5, 3'd4, 1'b0);
      9'h04E: e = kb_ent(3'd5, 3'd5, 1'b0);
      9'h055: e = kb_ent(3'd5, 3'd5, 1'b1);  // PC = is SHIFT+- on the MC-10
      9'h049: e = kb_ent(3'd5, 3'd6, 1'b0);
      9'h04A: e = kb_ent(3'd5, 3'd7, 1'b0);
      // row 6: CTRL, BREAK, SHIFT
      9'h014: e = kb_ent(ROW_SPECIAL, COL_CTRL,  1'b0);
      9'h076: e = kb_ent(ROW_SPECIAL, COL_BREAK, 1'b0);
      9'h012: e = kb_ent(ROW_SPECIAL, COL_SHIFT, 1'b0);
      9'h059: e = kb_ent(ROW_SPECIAL, COL_SHIFT, 1'b0);
      // extended: right CTRL, keypad Enter, arrows as the usual W/A/S/Z game keys
      9'h114: e = kb_ent(ROW_SPECIAL, COL_CTRL, 1'b0);
      9'h15A: e = kb_ent(3'd3, 3'd6, 1'b0);
      9'h175: e = kb_ent(3'd2, 3'd7, 1'b0);  // up    -> W
      9'h16B: e = kb_ent(3'd0, 3'd1, 1'b0);  // left  -> A
      9'h174: e = kb_ent(3'd2, 3'd3, 1'b0);  // right -> S
      9'h172: e = kb_ent(3'd3, 3'd2, 1'b0);  // down  -> Z
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mc10_kb_rom.sv
// Registered key-map lookup (pipeline stage 1). Unmapped or disabled
// extended codes leave this stage with valid low so they die here.
module mc10_kb_rom
  import mc10_kb_pkg::*;
#(
  parameter bit EXT_ENABLE = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_pressed,
  input  logic       in_ext,
  input  logic [7:0] in_code,
  output logic       out_valid,
  output logic       out_pressed,
  output kb_entry_t  out_entry
);

  kb_entry_t lookup_s;
  kb_entry_t entry_d, entry_q;
  logic      valid_d, valid_q;
  logic      pressed_d, pressed_q;

  // Table lookup, masking extended codes when they are not decoded.
  always_comb begin
    lookup_s  = kb_map({in_ext, in_code});
    entry_d   = lookup_s;
    if (in_ext && !EXT_ENABLE) begin
      entry_d.hit = 1'b0;
    end else begin
      entry_d.hit = lookup_s.hit;
    end
    valid_d   = in_valid & entry_d.hit;
    pressed_d = in_pressed;
  end

  // Stage-1 registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      entry_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
      entry_q   <= entry_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pressed = pressed_q;
  assign out_entry   = entry_q;

endmodule

// File: rtl/mc10_keymatrix.sv
// MC-10 keyboard matrix: PS/2 event word in, 7x8 key-state matrix with
// active-low column strobe / row readback and a counted virtual SHIFT.
module mc10_keymatrix
  import mc10_kb_pkg::*;
#(
  parameter int unsigned VSHIFT_W   = 3,
  parameter bit          EXT_ENABLE = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  kb_col,
  output logic [6:0]  kb_row,
  output logic        key_valid
);

  localparam logic [VSHIFT_W-1:0] VCNT_MAX = {VSHIFT_W{1'b1}};

  // arm_q is low for the first cycle after reset so the toggle history is
  // loaded from the live input instead of firing a stale event.
  logic                arm_q, arm_d;
  logic                tog_q, tog_d;
  logic                s0_valid_q, s0_valid_d;
  logic                s0_pressed_q, s0_pressed_d;
  logic                s0_ext_q, s0_ext_d;
  logic [7:0]          s0_code_q, s0_code_d;

  logic                s1_valid_s;
  logic                s1_pressed_s;
  kb_entry_t           s1_entry_s;

  logic [6:0][7:0]     matrix_q, matrix_d;
  logic [VSHIFT_W-1:0] vcnt_q, vcnt_d;
  logic                key_valid_q, key_valid_d;
  logic                cur_bit_s;
  logic [6:0]          row_hit_s;

  // Stage 0: detect a toggle flip and capture the event fields.
  always_comb begin
    arm_d      = 1'b1;
    tog_d      = ps2_key[10];
    s0_valid_d = arm_q & (ps2_key[10] != tog_q);
    if (s0_valid_d) begin
      s0_pressed_d = ps2_key[9];
      s0_ext_d     = ps2_key[8];
      s0_code_d    = ps2_key[7:0];
    end else begin
      s0_pressed_d = s0_pressed_q;
      s0_ext_d     = s0_ext_q;
      s0_code_d    = s0_code_q;
    end
  end

  // Stage-0 registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      arm_q        <= 1'b0;
      tog_q        <= 1'b0;
      s0_valid_q   <= 1'b0;
      s0_pressed_q <= 1'b0;
      s0_ext_q     <= 1'b0;
      s0_code_q    <= 8'h00;
    end else begin
      arm_q        <= arm_d;
      tog_q        <= tog_d;
      s0_valid_q   <= s0_valid_d;
      s0_pressed_q <= s0_pressed_d;
      s0_ext_q     <= s0_ext_d;
      s0_code_q    <= s0_code_d;
    end
  end

  mc10_kb_rom #(
    .EXT_ENABLE (EXT_ENABLE)
  ) u_rom (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .in_valid    (s0_valid_q),
    .in_pressed  (s0_pressed_q),
    .in_ext      (s0_ext_q),
    .in_code     (s0_code_q),
    .out_valid   (s1_valid_s),
    .out_pressed (s1_pressed_s),
    .out_entry   (s1_entry_s)
  );

  // Stage 2: write the matrix bit and track the virtual shift count using
  // the bit's old value so repeats and orphan releases do not move it.
  always_comb begin
    matrix_d    = matrix_q;
    vcnt_d      = vcnt_q;
    key_valid_d = 1'b0;
    cur_bit_s   = 1'b0;
    if (s1_valid_s && (s1_entry_s.row <= ROW_SPECIAL)) begin
      cur_bit_s   = matrix_q[s1_entry_s.row][s1_entry_s.col];
      key_valid_d = 1'b1;
      matrix_d[s1_entry_s.row][s1_entry_s.col] = s1_pressed_s;
      if (s1_entry_s.vshift && s1_pressed_s && !cur_bit_s && (vcnt_q != VCNT_MAX)) begin
        vcnt_d = vcnt_q + VSHIFT_W'(1);
      end else if (s1_entry_s.vshift && !s1_pressed_s && cur_bit_s && (vcnt_q != '0)) begin
        vcnt_d = vcnt_q - VSHIFT_W'(1);
      end else begin
        vcnt_d = vcnt_q;
      end
    end else begin
      matrix_d = matrix_q;
    end
  end

  // Matrix, shift count and event pulse registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      matrix_q    <= '0;
      vcnt_q      <= '0;
      key_valid_q <= 1'b0;
    end else begin
      matrix_q    <= matrix_d;
      vcnt_q      <= vcnt_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Combinational row readback for the CPU's column strobe.
  always_comb begin
    row_hit_s = 7'h00;
    for (int r = 0; r < 7; r++) begin
      row_hit_s[r] = |(matrix_q[r] & ~kb_col);
    end
    if ((vcnt_q != '0) && !kb_col[COL_SHIFT]) begin
      row_hit_s[ROW_SPECIAL] = 1'b1;
    end else begin
      row_hit_s[ROW_SPECIAL] = row_hit_s[ROW_SPECIAL];
    end
    if (reset) begin
      kb_row = 7'h7F;
    end else begin
      kb_row = ~row_hit_s;
    end
  end

  assign key_valid = key_valid_q;

endmodule
